regfile_mp: RTL and testbench

Parametrised multi-port register file, successor to the single-write processor register file. It provides three combinational read ports and two clocked write ports with fixed priority. An optional hard-wired zero register is supported. A hardware clear sweep zeroes every entry after reset or on request, with a `ready` handshake to the pipeline. It sits between decode (read addresses) and writeback (two retire lanes) in the processor datapath.

---
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: three combinational read ports, two prioritised write lanes,
// hardware clear sweep with ready handshake. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_mp #(
   parameter  int DBITS    = 32,
   parameter  int NREGS    = 16,
   parameter  int ZERO_REG = 1,
   localparam int ABITS    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   output logic             ready,
   input  logic             wrtEn0,
   input  logic             wrtEn1,
   input  logic [ABITS-1:0] wrtAddr0,
   input  logic [ABITS-1:0] wrtAddr1,
   input  logic [DBITS-1:0] wrtData0,
   input  logic [DBITS-1:0] wrtData1,
   input  logic [ABITS-1:0] rd,
   input  logic [ABITS-1:0] rs1,
   input  logic [ABITS-1:0] rs2,
   output logic [DBITS-1:0] outd,
   output logic [DBITS-1:0] out1,
   output logic [DBITS-1:0] out2
);

   typedef enum logic {CLEAR, READY} state_t;

   localparam logic [ABITS-1:0] LAST = ABITS'(NREGS - 1);

   state_t           state, state_nxt;
   logic [ABITS-1:0] ptr, ptr_nxt;
   logic [DBITS-1:0] registers [NREGS];
   logic             wr_ok0, wr_ok1;
   logic [ABITS-1:0] raddr [3];
   logic [DBITS-1:0] rdata [3];

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         CLEAR: begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == LAST) state_nxt = READY;
         end
         READY: begin
            if (clr) begin
               state_nxt = CLEAR;
               ptr_nxt   = '0;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   assign ready  = (state == READY);
   assign wr_ok0 = wrtEn0 && !(ZERO_REG != 0 && wrtAddr0 == '0);
   assign wr_ok1 = wrtEn1 && !(ZERO_REG != 0 && wrtAddr1 == '0);

   // NOTE: the array has no reset; the sweep clears it and the masked outputs hide the gap.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (state == CLEAR) begin
            registers[ptr] <= '0;
         end else begin
            if (wr_ok0) registers[wrtAddr0] <= wrtData0;
            if (wr_ok1) registers[wrtAddr1] <= wrtData1;
         end
      end
   end

   assign raddr[0] = rd;
   assign raddr[1] = rs1;
   assign raddr[2] = rs2;

   // Lane 1 is applied last so it wins on the forwarding path, matching the array priority.
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rdata[p] = '0;
         if (ready && !(ZERO_REG != 0 && raddr[p] == '0)) begin
            rdata[p] = registers[raddr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok0 && wrtAddr0 == raddr[p]) rdata[p] = wrtData0;
            if (wr_ok1 && wrtAddr1 == raddr[p]) rdata[p] = wrtData1;
`else
`endif
         end
      end
   end

   assign outd = rdata[0];
   assign out1 = rdata[1];
   assign out2 = rdata[2];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against a behavioural model (ready flag, sweep countdown, plain array).
module tb_regfile_mp;
   localparam int DBITS = 32;
   localparam int NREGS = 16;

   logic             clk = 1'b0;
   logic             reset_n, clr, ready;
   logic             wrtEn0, wrtEn1;
   logic [3:0]       wrtAddr0, wrtAddr1, rd, rs1, rs2;
   logic [DBITS-1:0] wrtData0, wrtData1, outd, out1, out2;

   int n_cmp = 0;
   int n_err = 0;

   // behavioural model state
   logic [DBITS-1:0] mem [NREGS];
   bit               m_ready = 1'b0;
   int               sweep_left = NREGS;

   always #5 clk = ~clk;

   regfile_mp #(.DBITS(DBITS), .NREGS(NREGS), .ZERO_REG(1)) dut (
      .clk(clk), .reset_n(reset_n), .clr(clr), .ready(ready),
      .wrtEn0(wrtEn0), .wrtEn1(wrtEn1), .wrtAddr0(wrtAddr0), .wrtAddr1(wrtAddr1),
      .wrtData0(wrtData0), .wrtData1(wrtData1),
      .rd(rd), .rs1(rs1), .rs2(rs2), .outd(outd), .out1(out1), .out2(out2)
   );

   task automatic idle();
      wrtEn0 = 1'b0;
      wrtEn1 = 1'b0;
      clr    = 1'b0;
   endtask

   task automatic rand_inputs();
      wrtEn0   = 1'($urandom_range(0, 1));
      wrtEn1   = 1'($urandom_range(0, 1));
      wrtAddr0 = 4'($urandom_range(0, NREGS - 1));
      wrtAddr1 = 4'($urandom_range(0, NREGS - 1));
      wrtData0 = $urandom;
      wrtData1 = $urandom;
      rd       = 4'($urandom_range(0, NREGS - 1));
      rs1      = 4'($urandom_range(0, NREGS - 1));
      rs2      = 4'($urandom_range(0, NREGS - 1));
   endtask

   // One rising edge; the model advances from the inputs the DUT just sampled.
   task automatic step();
      @(posedge clk);
      if (!reset_n) begin
         m_ready    = 1'b0;
         sweep_left = NREGS;
      end else if (!m_ready) begin
         sweep_left--;
         if (sweep_left == 0) begin
            m_ready = 1'b1;
            foreach (mem[i]) mem[i] = '0;
         end
      end else begin
         if (wrtEn0 && wrtAddr0 != 0) mem[wrtAddr0] = wrtData0;
         if (wrtEn1 && wrtAddr1 != 0) mem[wrtAddr1] = wrtData1;
         if (clr) begin
            m_ready    = 1'b0;
            sweep_left = NREGS;
         end
      end
      #1;
   endtask

   function automatic logic [DBITS-1:0] exp_read(input logic [3:0] a);
      logic [DBITS-1:0] v;
      if (!m_ready || a == 4'd0) return '0;
      v = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (wrtEn0 && wrtAddr0 == a) v = wrtData0;
      if (wrtEn1 && wrtAddr1 == a) v = wrtData1;
`endif
      return v;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      wrtAddr0 = '0; wrtAddr1 = '0; wrtData0 = '0; wrtData1 = '0;
      rd = 4'd1; rs1 = 4'd2; rs2 = 4'd3;
      repeat (3) begin
         step();
         n_cmp++;
         if ({ready, outd, out1, out2} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got ready=%b outs=%h/%h/%h expected all 0", ready, outd, out1, out2);
         end
      end
      reset_n = 1'b1;
      for (int i = 1; i <= NREGS; i++) begin
         rand_inputs();
         step();
         n_cmp++;
         if (ready !== (i == NREGS)) begin
            n_err++;
            $display("FAIL reset_sweep edge %0d: got ready=%b expected %b", i, ready, i == NREGS);
         end
      end
      idle();
      for (int a = 0; a < NREGS; a++) begin
         rd = 4'(a); rs1 = 4'(a); rs2 = 4'(a);
         #1;
         n_cmp++;
         if ({outd, out1, out2} !== '0) begin
            n_err++;
            $display("FAIL reset_zero addr %0d: got %h/%h/%h expected 0", a, outd, out1, out2);
         end
         step();
      end
   endtask

   task automatic test_basic_write();
      wrtEn0 = 1'b1; wrtAddr0 = 4'd5; wrtData0 = 32'hDEADBEEF; rs1 = 4'd5;
      step();
      idle();
      #1;
      n_cmp++;
      if (out1 !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL basic_write: got %h expected deadbeef", out1);
      end
   endtask

   task automatic test_lane_conflict();
      wrtEn0 = 1'b1; wrtAddr0 = 4'd7; wrtData0 = 32'h11;
      wrtEn1 = 1'b1; wrtAddr1 = 4'd7; wrtData1 = 32'h22;
      rs1 = 4'd7;
      step();
      idle();
      #1;
      n_cmp++;
      if (out1 !== 32'h22) begin
         n_err++;
         $display("FAIL lane_conflict: got %h expected 00000022", out1);
      end
   endtask

   task automatic test_zero_reg();
      wrtEn0 = 1'b1; wrtAddr0 = 4'd0; wrtData0 = 32'hFFFFFFFF;
      wrtEn1 = 1'b1; wrtAddr1 = 4'd0; wrtData1 = 32'hFFFFFFFF;
      rd = 4'd0;
      #1;
      n_cmp++;
      if (outd !== 32'h0) begin
         n_err++;
         $display("FAIL zero_reg_same_cycle: got %h expected 0", outd);
      end
      step();
      idle();
      #1;
      n_cmp++;
      if (outd !== 32'h0) begin
         n_err++;
         $display("FAIL zero_reg_after: got %h expected 0", outd);
      end
   endtask

   task automatic test_bypass();
      logic [DBITS-1:0] exp3, exp9;
      wrtEn0 = 1'b1; wrtAddr0 = 4'd3; wrtData0 = 32'h55;
      wrtEn1 = 1'b1; wrtAddr1 = 4'd9; wrtData1 = 32'h99;
      step();
      wrtEn0 = 1'b1; wrtAddr0 = 4'd3; wrtData0 = 32'h1234;
      wrtEn1 = 1'b0; rs2 = 4'd3;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp3 = 32'h1234;
`else
      exp3 = 32'h55;
`endif
      n_cmp++;
      if (out2 !== exp3) begin
         n_err++;
         $display("FAIL bypass_single: got %h expected %h", out2, exp3);
      end
      step();
      wrtEn0 = 1'b1; wrtAddr0 = 4'd9; wrtData0 = 32'hAAAA;
      wrtEn1 = 1'b1; wrtAddr1 = 4'd9; wrtData1 = 32'hBBBB;
      rs1 = 4'd9;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp9 = 32'hBBBB;
`else
      exp9 = 32'h99;
`endif
      n_cmp++;
      if ({out1, out2} !== {exp9, 32'h1234}) begin
         n_err++;
         $display("FAIL bypass_both_lanes: got %h/%h expected %h/00001234", out1, out2, exp9);
      end
      step();
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         rand_inputs();
         #1;
         n_cmp++;
         if ({ready, outd, out1, out2} !== {m_ready, exp_read(rd), exp_read(rs1), exp_read(rs2)}) begin
            n_err++;
            $display("FAIL random cycle %0d: got %b %h %h %h expected %b %h %h %h", c,
                     ready, outd, out1, out2, m_ready, exp_read(rd), exp_read(rs1), exp_read(rs2));
         end
         step();
      end
      idle();
   endtask

   task automatic test_clear();
      for (int a = 0; a < NREGS; a += 2) begin
         wrtEn0 = 1'b1; wrtAddr0 = 4'(a);     wrtData0 = 32'hA5A5A5A5;
         wrtEn1 = 1'b1; wrtAddr1 = 4'(a + 1); wrtData1 = 32'hA5A5A5A5;
         step();
      end
      idle();
      for (int a = 1; a < NREGS; a++) begin
         rs1 = 4'(a);
         #1;
         n_cmp++;
         if (out1 !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL clear_fill addr %0d: got %h expected a5a5a5a5", a, out1);
         end
      end
      clr = 1'b1;
      wrtEn0 = 1'b1; wrtAddr0 = 4'd4; wrtData0 = 32'h4444;
      step();
      clr = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         rand_inputs();
         #1;
         n_cmp++;
         if ({ready, outd, out1, out2} !== '0) begin
            n_err++;
            $display("FAIL clear_window cycle %0d: got ready=%b outs=%h/%h/%h expected all 0",
                     i, ready, outd, out1, out2);
         end
         step();
      end
      idle();
      for (int a = 0; a < NREGS; a++) begin
         rs2 = 4'(a);
         #1;
         n_cmp++;
         if ({ready, out2} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL clear_result addr %0d: got ready=%b data=%h expected ready=1 data=0", a, ready, out2);
         end
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (8) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      for (int i = 1; i <= NREGS; i++) begin
         rand_inputs();
         step();
         n_cmp++;
         if (ready !== (i == NREGS)) begin
            n_err++;
            $display("FAIL clear_restart edge %0d: got ready=%b expected %b", i, ready, i == NREGS);
         end
      end
      idle();
   endtask

   task automatic test_clr_held();
      clr = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         n_cmp++;
         if (ready !== (k % (NREGS + 1) == 0)) begin
            n_err++;
            $display("FAIL clr_held edge %0d: got ready=%b expected %b", k, ready, k % (NREGS + 1) == 0);
         end
      end
      clr = 1'b0;
      for (int k = 0; k < NREGS + 2; k++) begin
         step();
         n_cmp++;
         if (ready !== m_ready) begin
            n_err++;
            $display("FAIL clr_release edge %0d: got ready=%b expected %b", k, ready, m_ready);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_write();
      test_lane_conflict();
      test_zero_reg();
      test_bypass();
      test_random();
      test_clear();
      test_clr_held();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
